alu_reg32: RTL and testbench

//  32-bit RV32I-style integer ALU for the datapath execute stage, with registered outputs.
//  - Computes logic, shift, add/sub and set-less-than ops on operands a, b.
//  - Computes flags: overflow, zero, equal.
//  - Operands and outputs sit on a one-cycle valid pipeline.

---
 rtl/alu_reg32_pkg.sv | 54 +++++
 rtl/alu_reg32_if.sv | 24 ++
 rtl/alu_reg32_comb.sv | 76 +++++++
 rtl/alu_reg32.sv | 54 +++++
 tb/tb_alu_reg32.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_reg32_pkg.sv
// Shared types for the registered RV32I-style ALU: operation codes, output payload, helpers.
package alu_types_pkg;

    localparam int unsigned N = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1100,
        ALU_SLT  = 4'b1101,
        ALU_SLTU = 4'b1111
    } alu_control_t;

    typedef struct packed {
        logic [N-1:0] result;
        logic         overflow;
        logic         zero;
        logic         equal;
    } alu_out_t;

    localparam alu_out_t ALU_OUT_RST = '{result: '0, overflow: 1'b0, zero: 1'b1, equal: 1'b0};

    function automatic string alu_control_name(input alu_control_t c);
        case (c)
            ALU_AND:  return "AND";
            ALU_OR:   return "OR";
            ALU_XOR:  return "XOR";
            ALU_SLL:  return "SLL";
            ALU_SRL:  return "SRL";
            ALU_SRA:  return "SRA";
            ALU_ADD:  return "ADD";
            ALU_SUB:  return "SUB";
            ALU_SLT:  return "SLT";
            ALU_SLTU: return "SLTU";
            default:  return "UNDEF";
        endcase
    endfunction

    // Lets one right shifter also serve SLL.
    function automatic logic [N-1:0] bit_reverse(input logic [N-1:0] x);
        logic [N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            r[i] = x[N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_reg32_if.sv
// Operand/result bus between the execute stage and the ALU.
interface alu_reg32_if
    import alu_types_pkg::*;
;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    alu_control_t control;
    logic         out_valid;
    logic [N-1:0] result;
    logic         overflow;
    logic         zero;
    logic         equal;

    modport master (
        output in_valid, a, b, control,
        input  out_valid, result, overflow, zero, equal
    );

    modport slave (
        input  in_valid, a, b, control,
        output out_valid, result, overflow, zero, equal
    );
endinterface

// File: rtl/alu_reg32_comb.sv
// Combinational ALU core: one shared adder, one barrel shifter, result mux and flags.
module alu_comb
    import alu_types_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    output logic [N-1:0] result_c,
    output logic         overflow_c,
    output logic         zero_c,
    output logic         equal_c
);

    localparam int unsigned AW = N + 1;
    localparam int unsigned SW = 5;

    logic          sub_op;
    logic [N-1:0]  b_op;
    logic [AW-1:0] sum_full;
    logic [N-1:0]  sum;
    logic          carry;
    logic          ovf_add;
    logic          ovf_sub;
    logic [SW-1:0] shamt;
    logic          big_shift;
    logic          fill;
    logic [N-1:0]  sh_in;
    logic [N-1:0]  sh_out;

    // SUB/SLT/SLTU all compute a + ~b + 1 on the shared adder.
    always_comb begin
        sub_op   = (control == ALU_SUB) || (control == ALU_SLT) || (control == ALU_SLTU);
        b_op     = sub_op ? ~b : b;
        sum_full = AW'(a) + AW'(b_op) + AW'(sub_op);
        sum      = sum_full[N-1:0];
        carry    = sum_full[N];
        ovf_add  = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        ovf_sub  = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
    end

    // Amounts >= N saturate to the fill value; SLL is a reversed right shift.
    always_comb begin
        shamt     = b[SW-1:0];
        big_shift = |b[N-1:SW];
        fill      = (control == ALU_SRA) && a[N-1];
        sh_in     = (control == ALU_SLL) ? bit_reverse(a) : a;
        sh_out    = big_shift ? {N{fill}} : N'({{N{fill}}, sh_in} >> shamt);
    end

    always_comb begin
        result_c   = '0;
        overflow_c = 1'b0;
        case (control)
            ALU_AND:  result_c = a & b;
            ALU_OR:   result_c = a | b;
            ALU_XOR:  result_c = a ^ b;
            ALU_SLL:  result_c = bit_reverse(sh_out);
            ALU_SRL:  result_c = sh_out;
            ALU_SRA:  result_c = sh_out;
            ALU_ADD: begin
                result_c   = sum;
                overflow_c = ovf_add;
            end
            ALU_SUB: begin
                result_c   = sum;
                overflow_c = ovf_sub;
            end
            ALU_SLT:  result_c = {{(N-1){1'b0}}, sum[N-1] ^ ovf_sub};
            ALU_SLTU: result_c = {{(N-1){1'b0}}, ~carry};
            default:  result_c = '0;
        endcase
        zero_c  = (result_c == '0);
        equal_c = (a == b);
    end

endmodule

// File: rtl/alu_reg32.sv
// Execute-stage ALU with a one-cycle registered result, flags and valid bit.
module alu_reg32
    import alu_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    alu_reg32_if.slave  bus
);

    logic [N-1:0] result_c;
    logic         overflow_c;
    logic         zero_c;
    logic         equal_c;
    alu_out_t     out_d;
    alu_out_t     out_q;
    logic         valid_d;
    logic         valid_q;

    alu_comb u_comb (
        .a          (bus.a),
        .b          (bus.b),
        .control    (bus.control),
        .result_c   (result_c),
        .overflow_c (overflow_c),
        .zero_c     (zero_c),
        .equal_c    (equal_c)
    );

    // Outputs only load on a valid op, so idle-cycle operands never reach them.
    always_comb begin
        valid_d = bus.in_valid;
        out_d   = out_q;
        if (bus.in_valid) begin
            out_d = '{result: result_c, overflow: overflow_c, zero: zero_c, equal: equal_c};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            out_q   <= ALU_OUT_RST;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.result    = out_q.result;
    assign bus.overflow  = out_q.overflow;
    assign bus.zero      = out_q.zero;
    assign bus.equal     = out_q.equal;

endmodule

// File: tb/tb_alu_reg32.sv
// Scoreboard bench for alu_reg32: a driver queues expected results, a monitor checks them.
module tb_alu_reg32;
    import alu_types_pkg::*;

    typedef struct {
        logic [31:0]  result;
        logic         overflow;
        logic         zero;
        logic         equal;
        alu_control_t ctl;
    } exp_t;

    logic clk;
    logic rst_n;
    alu_reg32_if bus ();

    alu_reg32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    exp_t held;
    int   tests = 0;
    int   fails = 0;
    logic rst_seen = 1'b0;
    logic iv_seen  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from the arithmetic definitions of each op.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input alu_control_t c);
        exp_t   e;
        longint sa;
        longint sb;
        longint s;
        sa = $signed(a);
        sb = $signed(b);
        e.result   = 32'h0;
        e.overflow = 1'b0;
        e.ctl      = c;
        case (c)
            ALU_AND: e.result = a & b;
            ALU_OR:  e.result = a | b;
            ALU_XOR: e.result = a ^ b;
            ALU_SLL: e.result = (b >= 32) ? 32'h0 : a << b;
            ALU_SRL: e.result = (b >= 32) ? 32'h0 : a >> b;
            ALU_SRA: e.result = (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
            ALU_ADD: begin
                s = sa + sb;
                e.result   = a + b;
                e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUB: begin
                s = sa - sb;
                e.result   = a - b;
                e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SLT:  e.result = (sa < sb) ? 32'h1 : 32'h0;
            ALU_SLTU: e.result = (a < b) ? 32'h1 : 32'h0;
            default:  e.result = 32'h0;
        endcase
        e.zero  = (e.result == 32'h0);
        e.equal = (a == b);
        return e;
    endfunction

    // Drive one cycle; the op is expected out only if the sampling edge is not a reset edge.
    task automatic put(input logic v, input logic rst, input logic [31:0] a, input logic [31:0] b,
                       input alu_control_t c, input exp_t e);
        @(posedge clk);
        #1;
        rst_n       = rst;
        bus.in_valid = v;
        bus.a       = a;
        bus.b       = b;
        bus.control = c;
        if (v && rst) q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input alu_control_t c);
        put(1'b1, 1'b1, a, b, c, model(a, b, c));
    endtask

    task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input alu_control_t c,
                             input logic [31:0] res, input logic ovf);
        exp_t e;
        e.result   = res;
        e.overflow = ovf;
        e.zero     = (res == 32'h0);
        e.equal    = (a == b);
        e.ctl      = c;
        put(1'b1, 1'b1, a, b, c, e);
    endtask

    task automatic idle(input logic rst);
        exp_t e;
        e = model(32'h0, 32'h0, ALU_AND);
        put(1'b0, rst, 32'hxxxx_xxxx, 32'hxxxx_xxxx, ALU_AND, e);
    endtask

    always @(posedge clk) begin
        rst_seen = rst_n;
        iv_seen  = bus.in_valid;
    end

    // Monitor: every cycle check valid, then compare outputs to the popped or held entry.
    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(rst_seen && iv_seen));
        if (!rst_seen) begin
            held.result   = 32'h0;
            held.overflow = 1'b0;
            held.zero     = 1'b1;
            held.equal    = 1'b0;
            held.ctl      = ALU_AND;
        end else if (iv_seen) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: op completed with no queued expectation (t=%0t)", $time);
            end else begin
                held = q.pop_front();
            end
        end
        chk({"result ", alu_control_name(held.ctl)}, bus.result, held.result);
        chk({"overflow ", alu_control_name(held.ctl)}, 32'(bus.overflow), 32'(held.overflow));
        chk({"zero ", alu_control_name(held.ctl)}, 32'(bus.zero), 32'(held.zero));
        chk({"equal ", alu_control_name(held.ctl)}, 32'(bus.equal), 32'(held.equal));
    end

    logic [31:0] edge_v [9] = '{32'h0, 32'h1, 32'h2, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_001F, 32'h0000_0020};

    initial begin
        held.result   = 32'h0;
        held.overflow = 1'b0;
        held.zero     = 1'b1;
        held.equal    = 1'b0;
        held.ctl      = ALU_AND;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 32'h0;
        bus.b        = 32'h0;
        bus.control  = ALU_AND;
        idle(1'b0);
        idle(1'b0);

        // Every code, edge-value cross product plus random pairs.
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 9; i++)
                for (int j = 0; j < 9; j++)
                    issue(edge_v[i], edge_v[j], alu_control_t'(4'(c)));
            for (int r = 0; r < 25; r++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                ra = $urandom;
                rb = (r % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                if (r % 5 == 0) rb = ra;
                issue(ra, rb, alu_control_t'(4'(c)));
            end
            idle(1'b1);
        end

        issue_exp(32'h7FFF_FFFF, 32'h1,         ALU_ADD,  32'h8000_0000, 1'b1);
        issue_exp(32'h8000_0000, 32'h1,         ALU_SUB,  32'h7FFF_FFFF, 1'b1);
        issue_exp(32'h1234_5678, 32'h1234_5678, ALU_SUB,  32'h0,         1'b0);
        issue_exp(32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT,  32'h1,         1'b0);
        issue_exp(32'h8000_0000, 32'h7FFF_FFFF, ALU_SLTU, 32'h0,         1'b0);
        issue_exp(32'h8000_0000, 32'h1F,        ALU_SRA,  32'hFFFF_FFFF, 1'b0);
        issue_exp(32'h8000_0000, 32'h20,        ALU_SRA,  32'hFFFF_FFFF, 1'b0);
        issue_exp(32'h1,         32'h20,        ALU_SLL,  32'h0,         1'b0);
        issue_exp(32'hFFFF_FFFF, 32'h4,         ALU_SRL,  32'h0FFF_FFFF, 1'b0);

        // Single AND, then idle: result must hold while out_valid drops.
        issue_exp(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 32'hF000_F000, 1'b0);
        idle(1'b1);
        @(negedge clk);
        chk("ctl out_valid after op", 32'(bus.out_valid), 32'h1);
        chk("ctl result after op", bus.result, 32'hF000_F000);
        idle(1'b1);
        @(negedge clk);
        chk("ctl out_valid idle", 32'(bus.out_valid), 32'h0);
        chk("ctl result hold", bus.result, 32'hF000_F000);
        idle(1'b1);

        // Reset with an op presented on the same edge: op discarded.
        issue(32'h0000_0005, 32'h0000_0003, ALU_ADD);
        put(1'b1, 1'b0, 32'h1, 32'h1, ALU_ADD, model(32'h1, 32'h1, ALU_ADD));
        idle(1'b1);
        @(negedge clk);
        chk("rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst result", bus.result, 32'h0);
        chk("rst zero", 32'(bus.zero), 32'h1);
        chk("rst overflow", 32'(bus.overflow), 32'h0);
        chk("rst equal", 32'(bus.equal), 32'h0);

        issue(32'hDEAD_BEEF, 32'h0000_0010, ALU_SRA);
        idle(1'b1);
        idle(1'b1);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected results never appeared", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
